// File: rtl/alu_frame_pkg.sv
// Shared definitions for the ALU framed stream (framer and deframer sides).
package alu_frame_pkg;

    localparam int DATA_W        = 32;
    localparam int LEN_W         = 5;
    localparam int MAX_FRAME_LEN = (1 << LEN_W) - 1;

    typedef logic [LEN_W-1:0] frame_len_t;

    typedef enum logic {
        IDLE,
        SEND
    } rd_state_t;

endpackage

// File: rtl/alu_deframer_lq.sv
// Committed-frame length queue: small synchronous FIFO with a combinational head.
module alu_deframer_lq #(
    parameter int W     = alu_frame_pkg::LEN_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_len,
    input  logic         pop,
    output logic         empty,
    output logic         full,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;

    assign empty = (wp == rp);
    assign full  = ((wp - rp) == (AW+1)'(DEPTH));
    assign head  = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + (AW+1)'(1);
            if (pop && !empty) rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= push_len;
    end

endmodule

// File: rtl/alu_deframer.sv
// Receive side of the ALU framed stream: stores whole frames speculatively,
// commits or rewinds at frame end, and replays committed frames over valid/ready.
module alu_deframer #(
    parameter int DATA_W   = alu_frame_pkg::DATA_W,
    parameter int LEN_W    = alu_frame_pkg::LEN_W,
    parameter int DEPTH    = 32,
    parameter int LQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame,
    input  logic [DATA_W-1:0] frame_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eof,
    output logic [LEN_W-1:0]  out_len,
    output logic              drop_pulse,
    output logic [7:0]        drop_cnt
);

    import alu_frame_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = {LEN_W{1'b1}};

    logic              frame_r;
    logic [DATA_W-1:0] data_r;
    logic              armed, active, bad;
    logic [PW-1:0]     spec_wptr, wptr, rptr;
    logic [LEN_W-1:0]  cur_len, count;
    logic [DATA_W-1:0] mem [DEPTH];

    logic fifo_full, word_in, frame_end, frame_good, wr_en;
    logic lq_push, lq_pop, lq_empty, lq_full;
    logic [LEN_W-1:0] lq_head;

    rd_state_t state, state_nxt;

    // Arming looks at the raw input: frame_r resets to 0 and would otherwise
    // arm immediately, letting a frame in progress at reset release through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_r <= 1'b0;
            data_r  <= '0;
            armed   <= 1'b0;
        end else begin
            frame_r <= frame;
            data_r  <= frame_data;
            armed   <= armed | ~frame;
        end
    end

    assign fifo_full  = ((spec_wptr - rptr) == PW'(DEPTH));
    assign word_in    = armed && frame_r;
    assign frame_end  = active && !frame_r;
    assign frame_good = !bad && !lq_full;
    assign wr_en      = word_in && !bad && !fifo_full && (cur_len != MAX_LEN);
    assign lq_push    = frame_end && frame_good;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active     <= 1'b0;
            bad        <= 1'b0;
            cur_len    <= '0;
            spec_wptr  <= '0;
            wptr       <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            drop_pulse <= 1'b0;
            if (word_in) begin
                active <= 1'b1;
                if (wr_en) begin
                    spec_wptr <= spec_wptr + PW'(1);
                    cur_len   <= cur_len + LEN_W'(1);
                end else begin
                    bad <= 1'b1;
                end
            end else if (frame_end) begin
                active  <= 1'b0;
                bad     <= 1'b0;
                cur_len <= '0;
                if (frame_good) begin
                    wptr <= spec_wptr;
                end else begin
                    spec_wptr  <= wptr;
                    drop_pulse <= 1'b1;
                    if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[spec_wptr[AW-1:0]] <= data_r;
    end

    alu_deframer_lq #(
        .W     (LEN_W),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (lq_push),
        .push_len (cur_len),
        .pop      (lq_pop),
        .empty    (lq_empty),
        .full     (lq_full),
        .head     (lq_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        lq_pop    = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_sof   = 1'b0;
        out_eof   = 1'b0;
        case (state)
            IDLE: if (!lq_empty) state_nxt = SEND;
            SEND: begin
                out_valid = 1'b1;
                out_data  = mem[rptr[AW-1:0]];
                out_sof   = (count == '0);
                out_eof   = (count == out_len - LEN_W'(1));
                if (out_ready && out_eof) begin
                    lq_pop    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr    <= '0;
            count   <= '0;
            out_len <= '0;
        end else begin
            if (state == IDLE && !lq_empty) out_len <= lq_head;
            if (out_valid && out_ready) begin
                rptr  <= rptr + PW'(1);
                count <= out_eof ? '0 : count + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_deframer.sv
// Directed bench for alu_deframer: latency, stall hold, drop conditions and reset abort.
module tb_alu_deframer;

    logic        clk = 1'b0;
    logic        rst_n, frame, out_ready;
    logic [31:0] frame_data, out_data;
    logic        out_valid, out_sof, out_eof, drop_pulse;
    logic [4:0]  out_len;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int drop_seen = 0;

    logic [31:0] q_data[$];
    logic        q_sof[$];
    logic        q_eof[$];
    logic [4:0]  q_len[$];
    int          q_cyc[$];

    alu_deframer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame      (frame),
        .frame_data (frame_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .out_len    (out_len),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records accepted words and checks hold-while-stalled.
    initial begin
        logic        sp, ps, pe;
        logic [31:0] pd;
        logic [4:0]  pl;
        sp = 1'b0; ps = 1'b0; pe = 1'b0; pd = '0; pl = '0;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_sof.push_back(out_sof);
                q_eof.push_back(out_eof);
                q_len.push_back(out_len);
                q_cyc.push_back(cyc);
            end
            if (drop_pulse) drop_seen++;
            if (out_valid && !out_ready && sp) begin
                check("hold_data", out_data, pd);
                check("hold_sof", 32'(out_sof), 32'(ps));
                check("hold_eof", 32'(out_eof), 32'(pe));
                check("hold_len", 32'(out_len), 32'(pl));
            end
            sp = out_valid && !out_ready;
            pd = out_data; ps = out_sof; pe = out_eof; pl = out_len;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int id, input int n, output int last_cyc);
        last_cyc = 0;
        for (int i = 0; i < n; i++) begin
            frame      = 1'b1;
            frame_data = (id << 16) | i;
            last_cyc   = cyc;
            tick(1);
        end
        frame      = 1'b0;
        frame_data = '0;
        tick(1);
    endtask

    task automatic wait_out(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (q_data.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'(q_data.size() >= n), 32'd1);
    endtask

    task automatic expect_frame(input int id, input int n, input string tag);
        logic [31:0] d;
        logic        s, e;
        logic [4:0]  l;
        int          c;
        for (int i = 0; i < n; i++) begin
            if (q_data.size() == 0) begin
                check({tag, "_missing_word"}, 32'(i), 32'(n));
                break;
            end
            d = q_data.pop_front();
            s = q_sof.pop_front();
            e = q_eof.pop_front();
            l = q_len.pop_front();
            c = q_cyc.pop_front();
            check({tag, "_data"}, d, (id << 16) | i);
            check({tag, "_sof"}, 32'(s), 32'(i == 0));
            check({tag, "_eof"}, 32'(e), 32'(i == n - 1));
            check({tag, "_len"}, 32'(l), 32'(n));
        end
    endtask

    initial begin
        int lc, base;
        rst_n = 1'b0; frame = 1'b0; frame_data = '0; out_ready = 1'b0;
        tick(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sof", 32'(out_sof), 32'd0);
        check("rst_out_eof", 32'(out_eof), 32'd0);
        check("rst_out_len", 32'(out_len), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // single 3-word frame, consumer always ready
        out_ready = 1'b1;
        send_frame(1, 3, lc);
        wait_out(3, 20, "t1_timeout");
        if (q_cyc.size() >= 3) begin
            check("t1_latency", 32'(q_cyc[0] - lc), 32'd4);
            check("t1_back_to_back", 32'(q_cyc[2] - q_cyc[0]), 32'd2);
        end
        expect_frame(1, 3, "t1");
        check("t1_drop_cnt", 32'(drop_cnt), 32'd0);

        // two frames held back by a stalled consumer
        out_ready = 1'b0;
        send_frame(2, 2, lc);
        send_frame(3, 5, lc);
        tick(12);
        check("t2_stalled_none", 32'(q_data.size()), 32'd0);
        check("t2_stalled_valid", 32'(out_valid), 32'd1);
        check("t2_stalled_sof", 32'(out_sof), 32'd1);
        check("t2_stalled_data", out_data, 32'h0002_0000);
        check("t2_stalled_len", 32'(out_len), 32'd2);
        out_ready = 1'b1;
        wait_out(7, 40, "t2_timeout");
        expect_frame(2, 2, "t2a");
        expect_frame(3, 5, "t2b");
        tick(2);

        // data FIFO overflow: 15+15 stored, 5-word frame dropped, 2-word fits
        out_ready = 1'b0;
        base = drop_seen;
        send_frame(4, 15, lc);
        send_frame(5, 15, lc);
        send_frame(6, 5, lc);
        tick(3);
        check("t3_drop_pulse", 32'(drop_seen - base), 32'd1);
        check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
        send_frame(7, 2, lc);
        tick(4);
        out_ready = 1'b1;
        wait_out(32, 120, "t3_timeout");
        expect_frame(4, 15, "t3a");
        expect_frame(5, 15, "t3b");
        expect_frame(7, 2, "t3c");
        tick(5);
        check("t3_no_extra", 32'(q_data.size()), 32'd0);

        // over-length frame dropped, max-length frame delivered
        base = drop_seen;
        send_frame(8, 32, lc);
        tick(3);
        check("t4_drop_pulse", 32'(drop_seen - base), 32'd1);
        check("t4_drop_cnt", 32'(drop_cnt), 32'd2);
        check("t4_no_output", 32'(q_data.size()), 32'd0);
        send_frame(9, 31, lc);
        wait_out(31, 60, "t4_timeout");
        expect_frame(9, 31, "t4");

        // length queue full: fifth one-word frame dropped
        out_ready = 1'b0;
        base = drop_seen;
        for (int id = 10; id < 15; id++) send_frame(id, 1, lc);
        tick(3);
        check("t5_drop_pulse", 32'(drop_seen - base), 32'd1);
        check("t5_drop_cnt", 32'(drop_cnt), 32'd3);
        out_ready = 1'b1;
        wait_out(4, 40, "t5_timeout");
        for (int id = 10; id < 14; id++) expect_frame(id, 1, "t5");
        tick(10);
        check("t5_no_fifth", 32'(q_data.size()), 32'd0);

        // reset in the middle of a frame, released while frame is still high
        for (int i = 0; i < 3; i++) begin
            frame = 1'b1; frame_data = (15 << 16) | i; tick(1);
        end
        rst_n = 1'b0;
        frame_data = (15 << 16) | 3; tick(1);
        frame_data = (15 << 16) | 4; tick(1);
        rst_n = 1'b1;
        for (int i = 5; i < 8; i++) begin
            frame_data = (15 << 16) | i; tick(1);
        end
        frame = 1'b0; frame_data = '0;
        base = drop_seen;
        tick(15);
        check("t6_no_output", 32'(q_data.size()), 32'd0);
        check("t6_valid_low", 32'(out_valid), 32'd0);
        check("t6_drop_cnt", 32'(drop_cnt), 32'd0);
        check("t6_no_drop", 32'(drop_seen - base), 32'd0);
        send_frame(16, 4, lc);
        wait_out(4, 20, "t6_timeout");
        if (q_cyc.size() >= 1) check("t6_latency", 32'(q_cyc[0] - lc), 32'd4);
        expect_frame(16, 4, "t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
